// File: rtl/ap1000_irq_pkg.sv
// rtl/ap1000_irq_pkg.sv - source map, sizing defaults and FSM encoding for the AP1000 interrupt arbiter
package ap1000_irq_pkg;

  localparam int IRQ_NUM_SRC = 11;
  localparam int IRQ_VEC_W   = 4;

  localparam int IRQ_SRC_SYSACE = 0;
  localparam int IRQ_SRC_PMC_A  = 1;
  localparam int IRQ_SRC_PMC_B  = 2;
  localparam int IRQ_SRC_PMC_C  = 3;
  localparam int IRQ_SRC_PMC_D  = 4;
  localparam int IRQ_SRC_PS2_0  = 5;
  localparam int IRQ_SRC_PS2_1  = 6;
  localparam int IRQ_SRC_PS2_2  = 7;
  localparam int IRQ_SRC_PS2_3  = 8;
  localparam int IRQ_SRC_PS2_4  = 9;
  localparam int IRQ_SRC_PS2_5  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } irq_state_e;

  // Single conditional subtract is enough: callers never pass idx >= 2*n.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/ap1000_irq_sync_edge.sv
// rtl/ap1000_irq_sync_edge.sv - per-line 2-FF synchroniser, polarity normalise, edge/level qualify
module ap1000_irq_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit EDGE       = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_raw,
  output logic o_qual
);

  logic r_s1;
  logic r_s2;
  logic w_act;

  // Reset to the inactive raw level so leaving reset never looks like an edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1 <= ACTIVE_LOW;
      r_s2 <= ACTIVE_LOW;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_act = r_s2 ^ ACTIVE_LOW;

  generate
    if (EDGE) begin : g_edge
      logic r_act_d;
      always_ff @(posedge Clk) begin
        if (Rst) r_act_d <= 1'b0;
        else     r_act_d <= w_act;
      end
      assign o_qual = w_act & ~r_act_d;
    end else begin : g_level
      assign o_qual = w_act;
    end
  endgenerate

endmodule

// File: rtl/ap1000_irq_arbiter.sv
// rtl/ap1000_irq_arbiter.sv - board interrupt pending/enable/arbitrate/present with ack handshake
// Optional rotating priority when AP1000_IRQ_ROUND_ROBIN_EN is defined; fixed lowest-index otherwise.
module ap1000_irq_arbiter
  import ap1000_irq_pkg::*;
#(
  parameter int                 NUM_SRC         = IRQ_NUM_SRC,
  parameter int                 VEC_W           = IRQ_VEC_W,
  parameter logic [NUM_SRC-1:0] ACTIVE_LOW_MASK = 11'h7FE,
  parameter logic [NUM_SRC-1:0] EDGE_MASK       = 11'h001,
  parameter logic [NUM_SRC-1:0] ENABLE_INIT     = 11'h000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_SRC-1:0] Irq_in,
  input  logic               Enable_wr,
  input  logic [NUM_SRC-1:0] Enable_data,
  output logic [NUM_SRC-1:0] Enable_q,
  output logic [NUM_SRC-1:0] Pending,
  output logic               Irq_req,
  output logic [VEC_W-1:0]   Irq_vec,
  input  logic               Irq_ack
);

  logic [NUM_SRC-1:0] w_qual;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   w_win;
  logic               w_any;
  logic               w_ack;
  logic               w_irq_req;
  irq_state_e         r_state;
  irq_state_e         w_state_nxt;

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      ap1000_irq_sync_edge #(
        .ACTIVE_LOW (ACTIVE_LOW_MASK[g]),
        .EDGE       (EDGE_MASK[g])
      ) u_sync (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_raw  (Irq_in[g]),
        .o_qual (w_qual[g])
      );
    end
  endgenerate

  assign w_ack = (r_state == ST_PRESENT) && Irq_ack;
  assign w_clr = w_ack ? (NUM_SRC'(1) << r_vec) : '0;

  // Level bits track w_qual directly; edge bits are sticky and a same-cycle set beats the ack clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pending <= '0;
      r_enable  <= ENABLE_INIT;
    end else begin
      r_pending <= w_qual | (r_pending & EDGE_MASK & ~w_clr);
      if (Enable_wr) r_enable <= Enable_data;
    end
  end

  assign w_elig = r_pending & r_enable;
  assign w_any  = |w_elig;

`ifdef AP1000_IRQ_ROUND_ROBIN_EN
  logic [VEC_W-1:0] r_ptr;

  always_ff @(posedge Clk) begin
    if (Rst)        r_ptr <= '0;
    else if (w_ack) r_ptr <= VEC_W'(wrap_idx(int'(r_vec) + 1, NUM_SRC));
  end

  always_comb begin
    w_win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_elig[wrap_idx(int'(r_ptr) + k, NUM_SRC)])
        w_win = VEC_W'(wrap_idx(int'(r_ptr) + k, NUM_SRC));
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = VEC_W'(i);
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_PRESENT;
      ST_PRESENT: if (Irq_ack) w_state_nxt = ST_GAP;
      ST_GAP:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_irq_req = (r_state == ST_PRESENT);
  end

  always_ff @(posedge Clk) begin
    if (Rst)                            r_vec <= '0;
    else if (r_state == ST_IDLE && w_any) r_vec <= w_win;
  end

  assign Irq_req  = w_irq_req;
  assign Irq_vec  = r_vec;
  assign Pending  = r_pending;
  assign Enable_q = r_enable;

endmodule

// File: tb/tb_ap1000_irq_arbiter.sv
// tb/tb_ap1000_irq_arbiter.sv - directed table plus corner sequences for ap1000_irq_arbiter
module tb_ap1000_irq_arbiter;

  logic        Clk;
  logic        Rst;
  logic [10:0] Irq_in;
  logic        Enable_wr;
  logic [10:0] Enable_data;
  logic [10:0] Enable_q;
  logic [10:0] Pending;
  logic        Irq_req;
  logic [3:0]  Irq_vec;
  logic        Irq_ack;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [10:0] irq;
    logic        ewr;
    logic [10:0] edata;
    logic        ack;
    logic        req;
    logic [3:0]  vec;
    logic [10:0] pend;
    logic [10:0] en;
  } vec_t;

  vec_t       tbl [27];
  logic [3:0] exp6 [4];

  ap1000_irq_arbiter dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Irq_in      (Irq_in),
    .Enable_wr   (Enable_wr),
    .Enable_data (Enable_data),
    .Enable_q    (Enable_q),
    .Pending     (Pending),
    .Irq_req     (Irq_req),
    .Irq_vec     (Irq_vec),
    .Irq_ack     (Irq_ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (Irq_req !== 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, 32'(Irq_req), 32'd1);
  endtask

  initial begin
    // rst, irq, ewr, edata, ack | req, vec, pend, en
    tbl[0]  = '{1'b1, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h000};
    tbl[1]  = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h000};
    tbl[2]  = '{1'b0, 11'h7FF, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h000};
    tbl[3]  = '{1'b0, 11'h7FF, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h000};
    tbl[4]  = '{1'b0, 11'h7FF, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h001, 11'h000};
    tbl[5]  = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h001, 11'h000};
    tbl[6]  = '{1'b0, 11'h7FE, 1'b1, 11'h001, 1'b0, 1'b0, 4'd0, 11'h001, 11'h001};
    tbl[7]  = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b1, 4'd0, 11'h001, 11'h001};
    tbl[8]  = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0, 11'h000, 11'h001};
    tbl[9]  = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h001};
    tbl[10] = '{1'b0, 11'h7FE, 1'b1, 11'h7FF, 1'b0, 1'b0, 4'd0, 11'h000, 11'h7FF};
    tbl[11] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h7FF};
    tbl[12] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h7FF};
    tbl[13] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h082, 11'h7FF};
    tbl[14] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b1, 4'd1, 11'h082, 11'h7FF};
    tbl[15] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0, 11'h082, 11'h7FF};
    tbl[16] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h082, 11'h7FF};
    tbl[17] = '{1'b0, 11'h77C, 1'b0, 11'h000, 1'b0, 1'b1, 4'd1, 11'h082, 11'h7FF};
    tbl[18] = '{1'b0, 11'h77E, 1'b0, 11'h000, 1'b0, 1'b1, 4'd1, 11'h082, 11'h7FF};
    tbl[19] = '{1'b0, 11'h77E, 1'b0, 11'h000, 1'b0, 1'b1, 4'd1, 11'h082, 11'h7FF};
    tbl[20] = '{1'b0, 11'h77E, 1'b0, 11'h000, 1'b0, 1'b1, 4'd1, 11'h080, 11'h7FF};
    tbl[21] = '{1'b0, 11'h77E, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0, 11'h080, 11'h7FF};
    tbl[22] = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h080, 11'h7FF};
    tbl[23] = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b1, 4'd7, 11'h080, 11'h7FF};
    tbl[24] = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0, 11'h000, 11'h7FF};
    tbl[25] = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h7FF};
    tbl[26] = '{1'b0, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0, 11'h000, 11'h7FF};

`ifdef AP1000_IRQ_ROUND_ROBIN_EN
    exp6[0] = 4'd1; exp6[1] = 4'd2; exp6[2] = 4'd5; exp6[3] = 4'd1;
`else
    exp6[0] = 4'd1; exp6[1] = 4'd1; exp6[2] = 4'd1; exp6[3] = 4'd1;
`endif

    Rst = 1'b1; Irq_in = 11'h7FE; Enable_wr = 1'b0; Enable_data = '0; Irq_ack = 1'b0;

    for (int i = 0; i < 27; i++) begin
      Rst         = tbl[i].rst;
      Irq_in      = tbl[i].irq;
      Enable_wr   = tbl[i].ewr;
      Enable_data = tbl[i].edata;
      Irq_ack     = tbl[i].ack;
      @(negedge Clk);
      chk($sformatf("row%0d_req", i), 32'(Irq_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("row%0d_vec", i), 32'(Irq_vec), 32'(tbl[i].vec));
      chk($sformatf("row%0d_pend", i), 32'(Pending), 32'(tbl[i].pend));
      chk($sformatf("row%0d_en", i), 32'(Enable_q), 32'(tbl[i].en));
    end
    Enable_wr = 1'b0; Irq_ack = 1'b0;

    // Edge source 0: new rising edge lands in the ack cycle
    Irq_in = 11'h7FF;
    wait_req("t3_first_req");
    chk("t3_first_vec", 32'(Irq_vec), 32'd0);
    Irq_in = 11'h7FE;
    step(4);
    Irq_in = 11'h7FF;
    step(2);
    Irq_ack = 1'b1;
    step(1);
    Irq_ack = 1'b0;
    chk("t3_pend_kept", 32'(Pending[0]), 32'd1);
    chk("t3_gap_req", 32'(Irq_req), 32'd0);
    step(1);
    chk("t3_idle_req", 32'(Irq_req), 32'd0);
    step(1);
    chk("t3_rereq", 32'(Irq_req), 32'd1);
    chk("t3_revec", 32'(Irq_vec), 32'd0);
    Irq_ack = 1'b1;
    step(1);
    Irq_ack = 1'b0;
    chk("t3_cleared", 32'(Pending[0]), 32'd0);
    Irq_in = 11'h7FE;
    step(4);
    chk("t3_quiet", 32'(Irq_req), 32'd0);

    // Disable the presented source: request held until ack, then not re-presented
    Irq_in = 11'h7F6;
    wait_req("t4_req");
    chk("t4_vec", 32'(Irq_vec), 32'd3);
    Enable_wr = 1'b1; Enable_data = 11'h7F7;
    step(1);
    Enable_wr = 1'b0;
    chk("t4_en", 32'(Enable_q), 32'h7F7);
    chk("t4_req_held", 32'(Irq_req), 32'd1);
    step(2);
    chk("t4_req_held2", 32'(Irq_req), 32'd1);
    chk("t4_vec_held", 32'(Irq_vec), 32'd3);
    Irq_ack = 1'b1;
    step(1);
    Irq_ack = 1'b0;
    chk("t4_req_drop", 32'(Irq_req), 32'd0);
    chk("t4_pend3", 32'(Pending[3]), 32'd1);
    step(3);
    chk("t4_not_represented", 32'(Irq_req), 32'd0);
    Irq_in = 11'h7FE; Enable_wr = 1'b1; Enable_data = 11'h7FF;
    step(1);
    Enable_wr = 1'b0;
    step(3);
    chk("t4_pend_clear", 32'(Pending), 32'h000);

    // Reset mid-handshake
    Irq_in = 11'h7FF;
    wait_req("t5_req");
    Rst = 1'b1; Irq_in = 11'h7FE;
    step(1);
    Rst = 1'b0;
    chk("t5_req", 32'(Irq_req), 32'd0);
    chk("t5_pend", 32'(Pending), 32'h000);
    chk("t5_en", 32'(Enable_q), 32'h000);
    step(4);
    chk("t5_no_post_reset_edge", 32'(Pending), 32'h000);

    // Bits 1, 2, 5 held active: presentation order depends on priority mode
    Enable_wr = 1'b1; Enable_data = 11'h7FF;
    step(1);
    Enable_wr = 1'b0;
    Irq_in = 11'h7D8;
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("t6_req%0d", k));
      chk($sformatf("t6_vec%0d", k), 32'(Irq_vec), 32'(exp6[k]));
      Irq_ack = 1'b1;
      step(1);
      Irq_ack = 1'b0;
      chk($sformatf("t6_drop%0d", k), 32'(Irq_req), 32'd0);
    end
    Irq_in = 11'h7FE;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ap1000_irq_arbiter.md
Name: ap1000_irq_arbiter

Overview:
Collects the board interrupt lines (SystemACE, PMC INTA-D, six PS/2 lines) after the pad-level interrupt interface. Synchronises, normalises polarity, and edge- or level-qualifies each line, then latches it in a pending register gated by a software enable mask. Selects one winner, presents it to the processor-side interrupt input as a single request plus vector, and holds it until acknowledged.

Parameters:
NUM_SRC, 11, number of interrupt sources; index map: 0 = sysace, 1-4 = PMC a-d, 5-10 = PS2 int0-5
VEC_W, 4, vector width; must satisfy 2**VEC_W >= NUM_SRC
ACTIVE_LOW_MASK, 11'h7FE, bit=1 means the raw line is active-low
EDGE_MASK, 11'h001, bit=1 means the source is edge-triggered (sticky pending); bit=0 means level
ENABLE_INIT, 11'h000, enable register value after reset

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Irq_in  in  NUM_SRC  raw interrupt lines, asynchronous to Clk
Enable_wr  in  1  write strobe for the enable register
Enable_data  in  NUM_SRC  new enable mask
Enable_q  out  NUM_SRC  current enable mask
Pending  out  NUM_SRC  current pending vector (before enable gating)
Irq_req  out  1  interrupt request to processor
Irq_vec  out  VEC_W  index of the presented source; valid while Irq_req=1
Irq_ack  in  1  acknowledge; sampled only while Irq_req=1

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset values:
  - sync flops: inactive level (no post-reset edge)
  - pending = 0
  - Enable_q = ENABLE_INIT
  - Irq_req = 0, Irq_vec = 0
  - state = IDLE
  - rotate pointer = 0
- Reset asserted mid-handshake abandons the request; Irq_req is low the next cycle.
- Input path:
  - 2-FF synchroniser, then XOR with ACTIVE_LOW_MASK to give active-high `act`.
  - Edge sources: rising edge of `act` (registered previous value) sets pending.
  - Level sources: pending = registered `act`, updated every cycle.
- Input latency: a raw assertion first visible at a Clk edge sets Pending 3 cycles later (2 sync + 1 detect/latch).
- Pending behaviour:
  - Pending latches regardless of enable.
  - Arbitration sees `elig` = Pending & Enable_q.
- Enable_wr updates Enable_q on the next edge. Disabling the source currently presented does NOT retract Irq_req; it stays up until acked.
- FSM:
  - IDLE: if elig != 0, register the winner into Irq_vec, set Irq_req=1, go to PRESENT. Irq_req therefore rises 1 cycle after elig becomes nonzero.
  - PRESENT: Irq_req and Irq_vec are held stable. On Irq_ack=1, clear pending[Irq_vec] if it is an edge source, drop Irq_req next cycle, go to GAP.
  - GAP: one cycle with Irq_req=0 (guarantees a visible deassertion), then IDLE.
  - Minimum back-to-back spacing: ack cycle, GAP, IDLE, then the next PRESENT. Irq_req is low for 2 cycles.
- Boundary cases:
  - Same-cycle new edge on the source being acked: set wins, and the source stays pending.
  - A level source that is still active after ack is re-presented after GAP.
  - A level source that deasserts during PRESENT is still presented until acked; the ack then clears nothing.
  - Irq_ack while not in PRESENT is ignored.
- Fixed priority (default): lowest index in elig wins (sysace highest).

Optional Feature:
Macro AP1000_IRQ_ROUND_ROBIN_EN.
- Defined: rotating priority. Search starts at the pointer and wraps modulo NUM_SRC. On each ack the pointer becomes Irq_vec+1, wrapping NUM_SRC-1 to 0.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Shared include ap1000_irq_pkg.vh holds:
  - source index constants (IRQ_SRC_SYSACE=0 ... IRQ_SRC_PS2_5=10)
  - NUM_SRC default
  - FSM state encodings IDLE/PRESENT/GAP
- One sub-module, ap1000_irq_sync_edge: per-source 2-FF synchroniser, polarity invert, and edge/level qualify. Parameters ACTIVE_LOW and EDGE; output is the single-cycle set pulse or the level. Instantiated NUM_SRC times in a generate loop.

Test Plan:
1. Reset with ENABLE_INIT=0, pulse Irq_in[0] low->high -> Pending[0]=1 after 3 cycles, Irq_req stays 0; write Enable_data=11'h001 -> Irq_req=1 and Irq_vec=0 one cycle after Enable_q updates.
2. All enabled; hold PMC_inta (bit1) and PS2_int2 (bit7) low together -> Irq_vec=1 first. Ack -> Irq_req low 2 cycles, then Irq_vec=1 again while bit1 is still low. Release bit1 -> next vector is 7.
3. Edge source 0: re-assert a new rising edge in the exact ack cycle -> Pending[0] remains 1, and 0 is re-presented after GAP.
4. Present vector 3, then write Enable_data clearing bit3 -> Irq_req stays 1 and Irq_vec=3 until ack; not re-presented afterwards.
5. Assert Rst while Irq_req=1 -> next cycle Irq_req=0, Pending=0, Enable_q=ENABLE_INIT.
6. With AP1000_IRQ_ROUND_ROBIN_EN, hold bits 1, 2, 5 active -> presentation order 1, 2, 5, 1, ...; without the macro -> 1, 1, 1, ...
